// File: rtl/priority_encoder_4to2_pkg.sv
// Shared constants and helpers for the priority encoder slice.
package pe_pkg;

    localparam int PE_N_DEFAULT = 4;

    function automatic int pe_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/priority_encoder_4to2_if.sv
// Request/result bundle between a requester and the registered priority encoder.
interface priority_encoder_4to2_if
    import pe_pkg::*;
#(
    parameter int N = PE_N_DEFAULT
);
    localparam int W = pe_width(N);

    logic         en;
    logic [N-1:0] val;
    logic [W-1:0] y;
    logic         valid;

    modport master (
        output en,
        output val,
        input  y,
        input  valid
    );

    modport slave (
        input  en,
        input  val,
        output y,
        output valid
    );

endinterface

// File: rtl/priority_encoder_4to2_core.sv
// Combinational priority reduction: index of the most-significant set bit.
module priority_encoder_core
    import pe_pkg::*;
#(
    parameter int N = PE_N_DEFAULT,
    localparam int W = pe_width(N)
) (
    input  logic [N-1:0] val,
    output logic [W-1:0] idx,
    output logic         any_set
);

    always_comb begin
        idx     = '0;
        any_set = |val;
        // Ascending scan: a later (higher) set bit overwrites any lower one.
        for (int unsigned i = 0; i < N; i++) begin
            if (val[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_encoder_4to2.sv
// Registered priority encoder: one-cycle latency, enable hold, sync active-high reset.
module priority_encoder_4to2
    import pe_pkg::*;
#(
    parameter int N = PE_N_DEFAULT,
    localparam int W = pe_width(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    priority_encoder_4to2_if.slave bus
);

    logic [W-1:0] w_idx;
    logic         w_any;
    logic [W-1:0] r_y;
    logic         r_valid;

    priority_encoder_core #(
        .N (N)
    ) u_core (
        .val     (bus.val),
        .idx     (w_idx),
        .any_set (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else if (bus.en) begin
            r_y     <= w_idx;
            r_valid <= w_any;
        end
    end

    assign bus.y     = r_y;
    assign bus.valid = r_valid;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Scoreboard bench for the registered 4-to-2 priority encoder.
module tb_priority_encoder_4to2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    priority_encoder_4to2_if #(.N(4)) bus ();

    priority_encoder_4to2 #(
        .N (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [2:0] sb_q[$];
    logic [1:0] m_y     = 2'b00;
    logic       m_valid = 1'b0;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got valid/y=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_enc(input logic [3:0] v);
        casez (v)
            4'b1???: return 2'b11;
            4'b01??: return 2'b10;
            4'b001?: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Drive one edge worth of stimulus, predict the registered result, then compare.
    task automatic step(input string tag, input logic r, input logic e, input logic [3:0] v);
        logic [2:0] exp;
        rst     = r;
        bus.en  = e;
        bus.val = v;
        if (r) begin
            m_y     = 2'b00;
            m_valid = 1'b0;
        end else if (e) begin
            m_y     = ref_enc(v);
            m_valid = |v;
        end
        sb_q.push_back({m_valid, m_y});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, {bus.valid, bus.y}, 3'bxxx);
        end else begin
            exp = sb_q.pop_front();
            check(tag, {bus.valid, bus.y}, exp);
        end
    endtask

    initial begin
        logic [3:0] order[16];
        bus.en  = 1'b1;
        bus.val = 4'b1111;

        // Reset held two cycles with requests present
        step("rst0", 1'b1, 1'b1, 4'b1111);
        step("rst1", 1'b1, 1'b1, 4'b1111);
        step("rst_rel", 1'b0, 1'b1, 4'b1111);

        // Single-bit sweep
        step("bit0", 1'b0, 1'b1, 4'b0001);
        step("bit1", 1'b0, 1'b1, 4'b0010);
        step("bit2", 1'b0, 1'b1, 4'b0100);
        step("bit3", 1'b0, 1'b1, 4'b1000);

        // Zero, full and mixed patterns
        step("zero", 1'b0, 1'b1, 4'b0000);
        step("full", 1'b0, 1'b1, 4'b1111);
        step("p0110", 1'b0, 1'b1, 4'b0110);
        step("p0011", 1'b0, 1'b1, 4'b0011);

        // Enable hold
        step("hold_cap", 1'b0, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 4'b0001);
        step("hold_rel", 1'b0, 1'b1, 4'b0001);

        // Reset mid-operation
        step("mid_cap", 1'b0, 1'b1, 4'b0100);
        step("mid_rst", 1'b1, 1'b1, 4'b1000);
        step("mid_resume", 1'b0, 1'b1, 4'b1000);

        // Reset while disabled still clears
        step("rst_noen", 1'b1, 1'b0, 4'b1111);
        step("after_rst_hold", 1'b0, 1'b0, 4'b1111);

        // Exhaustive in shuffled order with random enable
        for (int i = 0; i < 16; i++) order[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            int j;
            logic [3:0] t;
            j = int'($urandom_range(i, 0));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                step("exh", 1'b0, 1'($urandom_range(1, 0)), order[i]);
            end
        end
        for (int i = 0; i < 16; i++) step("exh_en", 1'b0, 1'b1, order[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
